// File: rtl/tx_fifo_arb.sv
// tx_fifo_arb: owns the TX FIFO read port and hands it to one of two
// requesters (UART bypass or softmax) a whole frame at a time.
//
// Parameters:
//   FRAME_LEN  words per frame (>=2); the grant is re-evaluated only after
//              this many pops.
//   TIMEOUT    idle cycles (no pop) inside a frame before it is aborted (>=4).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   control[1:0]          00 off, 01 UART, 10 softmax, 11 reserved (error)
//   fifo_data/fifo_empty  TX FIFO read side; fifo_rd_en is the read strobe
//   ua_rd_en/ua_data/ua_empty  UART requester view of the FIFO
//   sm_rd_en/sm_data/sm_empty  softmax requester view of the FIFO
//   owner[1:0]            current grant: 00 none, 01 UART, 10 softmax
//   frame_abort           one-cycle pulse after a frame times out
//   ctrl_err              sticky: control==11 seen while idle
//   frame_cnt[15:0]       completed frames (saturating)
//
// Build option: define TX_FIFO_ARB_STATS_EN to build the frame_cnt counter;
// otherwise frame_cnt is tied to zero.
module tx_fifo_arb #(
  parameter int FRAME_LEN = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  control,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        ua_rd_en,
  output logic [15:0] ua_data,
  output logic        ua_empty,
  input  logic        sm_rd_en,
  output logic [15:0] sm_data,
  output logic        sm_empty,
  output logic [1:0]  owner,
  output logic        frame_abort,
  output logic        ctrl_err,
  output logic [15:0] frame_cnt
);

  localparam int WCW = $clog2(FRAME_LEN);
  localparam int ICW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] W_LAST = WCW'(FRAME_LEN - 1);
  localparam logic [ICW-1:0] I_LAST = ICW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT_UA, GRANT_SM, GAP} state_e;

  state_e         state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic           abort_q, abort_d;
  logic           err_q, err_d;

  logic ua_sel, sm_sel, pop, last_pop;

  // Datapath is purely combinational from the registered owner, so the
  // FIFO read latency seen by the granted requester is unchanged.
  assign ua_sel     = (owner_q == 2'b01);
  assign sm_sel     = (owner_q == 2'b10);
  assign ua_data    = ua_sel ? fifo_data : '0;
  assign sm_data    = sm_sel ? fifo_data : '0;
  assign ua_empty   = ua_sel ? fifo_empty : 1'b1;
  assign sm_empty   = sm_sel ? fifo_empty : 1'b1;
  assign pop        = ((ua_sel & ua_rd_en) | (sm_sel & sm_rd_en)) & ~fifo_empty;
  assign last_pop   = pop & (wcnt_q == W_LAST);
  assign fifo_rd_en = pop;

  assign owner       = owner_q;
  assign frame_abort = abort_q;
  assign ctrl_err    = err_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    abort_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Grant is taken regardless of FIFO level; the frame then either
        // fills or times out.
        case (control)
          2'b01: begin state_d = GRANT_UA; owner_d = 2'b01; icnt_d = '0; end
          2'b10: begin state_d = GRANT_SM; owner_d = 2'b10; icnt_d = '0; end
          2'b11: err_d = 1'b1;
          default: ;
        endcase
      end
      GRANT_UA, GRANT_SM: begin
        // control is deliberately not looked at here: frames are never split.
        if (pop) begin
          icnt_d = '0;
          if (last_pop) begin
            wcnt_d  = '0;
            state_d = GAP;
            owner_d = 2'b00;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if (icnt_q == I_LAST) begin
          abort_d = 1'b1;
          wcnt_d  = '0;
          icnt_d  = '0;
          state_d = GAP;
          owner_d = 2'b00;
        end else begin
          icnt_d = icnt_q + 1'b1;
        end
      end
      default: begin
        // GAP: one dead cycle between frames, owner already 00.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'b00;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

`ifdef TX_FIFO_ARB_STATS_EN
  logic [15:0] fcnt_q, fcnt_d;

  // last_pop implies a grant state (owner is non-zero only there).
  always_comb begin
    fcnt_d = fcnt_q;
    if (last_pop && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
